np_uart_rx: RTL and testbench
=============================

Name: np_uart_rx

Overview:
- Hardware 8N1 UART receiver for the np_top SERIAL_RX pin; the receive-side counterpart of the SoC's serial transmitter.
- Oversamples with a fixed clock divider and validates the start bit at mid-bit. Samples data LSB-first and checks the stop bit.
- Presents each received byte on a one-entry valid/ready holding register for the SoC bus glue, with framing-error and overrun reporting.

Parameters:
- CLKS_PER_BIT, 106, CLK cycles per bit; must be >= 4. Half-bit = CLKS_PER_BIT/2, truncated; 53 at default.

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous, active-low reset
- RX  in  1  raw serial input; asynchronous to CLK, idles high
- RX_DATA  out  8  received byte; stable while RX_VALID=1
- RX_VALID  out  1  holding register full
- RX_READY  in  1  consumer accepts byte when RX_VALID&&RX_READY at a rising CLK edge
- FRAME_ERR  out  1  one-cycle pulse: stop bit sampled low
- OVERRUN  out  1  sticky: a completed byte was dropped because the holding register was full
- ERR_CLR  in  1  clears OVERRUN

Behaviour:
- Reset (RST=0, asynchronous):
  - synchronizer flops=1, FSM=IDLE, bit counter=0, shift register=0
  - RX_DATA=0, RX_VALID=0, FRAME_ERR=0, OVERRUN=0
- RX passes through a 2-flop synchronizer (rx_s) before any use; this adds 2 cycles of input latency.
- FSM, with down-counter cnt:
  - IDLE:
    - rx_s==0 -> START, cnt=HALF-1.
  - START:
    - Decrement until cnt==0, then sample.
    - rx_s==1 is a false start: -> IDLE, no output, no error.
    - Otherwise -> DATA, cnt=CLKS_PER_BIT-1, bit index=0.
  - DATA:
    - At cnt==0, shift rx_s into the MSB of shreg (shreg={rx_s,shreg[7:1]}), reload cnt.
    - After the 8th sample -> STOP.
  - STOP:
    - At cnt==0, sample.
    - rx_s==1 -> deliver shreg, -> IDLE.
    - rx_s==0 -> FRAME_ERR=1 for exactly one cycle, byte discarded, -> BREAK.
  - BREAK:
    - Wait for rx_s==1 -> IDLE. Line-low (break) never starts a new frame.
- Delivery, in the cycle after the stop sample:
  - Holding register empty, or being consumed this same cycle (RX_VALID&&RX_READY): RX_DATA<=shreg, RX_VALID<=1.
  - Otherwise: OVERRUN<=1, new byte dropped, RX_DATA/RX_VALID unchanged.
- Consumption:
  - RX_VALID&&RX_READY with no simultaneous delivery -> RX_VALID<=0. RX_DATA holds its last value.
  - RX_READY while RX_VALID=0 has no effect.
- OVERRUN:
  - Cleared by ERR_CLR=1.
  - Set and clear in the same cycle: set wins.
- Latency:
  - Falling RX edge to RX_VALID is about 2 + HALF + 9*CLKS_PER_BIT + 1 cycles.
  - RX_VALID rises one cycle after the stop-bit sample.
- Back-to-back frames:
  - IDLE is re-entered at mid-stop-bit, so a start edge arriving half a bit later is caught.
  - No dead time beyond the synchronizer.
- Reset asserted mid-frame aborts immediately.
  - After release the FSM stays in IDLE until it sees a new falling edge on rx_s.
  - A partial frame is never delivered.
- Counter width: $clog2(CLKS_PER_BIT). Bit index: 3 bits, no wrap beyond 7.

Decomposition:
- Shared package np_uart_pkg:
  - FSM state encoding (IDLE, START, DATA, STOP, BREAK)
  - NP_UART_DATA_W=8
  - NP_UART_CLKS_PER_BIT_DEFAULT=106
  - This package is shared with the future np_uart_tx.
- Sub-module np_sync2: 2-flop synchronizer with reset value parameter (1 for RX). It is reusable for other asynchronous pins.

Test Plan (CLKS_PER_BIT=106, one bit = 106 CLK; the bench drives RX with a task):
1. RX_READY=1, send 0x41 -> exactly one RX_VALID cycle with RX_DATA=0x41. FRAME_ERR=0, OVERRUN=0. RX_VALID rises 2+53+9*106+1 (±2) cycles after the start edge.
2. Pull RX low for 20 cycles, then high -> no RX_VALID, no FRAME_ERR. A following frame 0xA5 is received as 0xA5.
3. Send 0x55 with stop bit forced low for 3 bits, then high -> one-cycle FRAME_ERR pulse, RX_VALID stays 0. The next frame 0x0F, sent after the line returns high, is received as 0x0F.
4. RX_READY=0, send 0x11 then 0x22 -> RX_DATA=0x11, RX_VALID=1, OVERRUN=1. Pulse RX_READY -> RX_VALID=0. Pulse ERR_CLR -> OVERRUN=0.
5. RX_READY=1, send 0x00, 0xFF, 0x80 back-to-back with no idle gap -> three deliveries in order, no errors.
6. Assert RST for 5 cycles during bit 4 of 0x3C, release mid-frame -> all outputs 0 during reset, no delivery of the partial frame. The next full frame 0xC3 is received as 0xC3.

Source files
------------

// File: rtl/np_uart_pkg.sv
// Shared UART definitions for the np receive and transmit paths: FSM state encoding and data width.
// Carries no logic of its own.
package np_uart_pkg;

  localparam int NP_UART_DATA_W               = 8;
  localparam int NP_UART_CLKS_PER_BIT_DEFAULT = 106;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } uart_state_t;

endpackage

// File: rtl/np_sync2.sv
// Two-flop synchronizer for an asynchronous input pin; 2-cycle latency, reset value selectable.
// No backpressure: samples every clock.
module np_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/np_uart_rx.sv
// 8N1 UART receiver with one-entry valid/ready holding register; RX_VALID rises one cycle after the stop sample.
// A byte that completes while the holding register is full and not being drained is dropped and flags OVERRUN.
module np_uart_rx
  import np_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = NP_UART_CLKS_PER_BIT_DEFAULT
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX,
  output logic [NP_UART_DATA_W-1:0] RX_DATA,
  output logic                      RX_VALID,
  input  logic                      RX_READY,
  output logic                      FRAME_ERR,
  output logic                      OVERRUN,
  input  logic                      ERR_CLR
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic                      rx_s;
  uart_state_t               state, state_nxt;
  logic [CNT_W-1:0]          cnt, cnt_nxt;
  logic [2:0]                idx, idx_nxt;
  logic [NP_UART_DATA_W-1:0] shreg, shreg_nxt;
  logic                      deliver;
  logic                      ferr_nxt;

  np_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (CLK),
    .rst_n (RST),
    .d     (RX),
    .q     (rx_s)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= ST_IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      shreg <= shreg_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    shreg_nxt = shreg;
    deliver   = 1'b0;
    ferr_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!rx_s) begin
          state_nxt = ST_START;
          cnt_nxt   = CNT_HALF;
        end
      end
      ST_START: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_ONE;
        end else if (rx_s) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_DATA;
          cnt_nxt   = CNT_BIT;
          idx_nxt   = '0;
        end
      end
      ST_DATA: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_ONE;
        end else begin
          shreg_nxt = {rx_s, shreg[NP_UART_DATA_W-1:1]};
          cnt_nxt   = CNT_BIT;
          if (idx == 3'd7) state_nxt = ST_STOP;
          else             idx_nxt   = idx + 3'd1;
        end
      end
      ST_STOP: begin
        // Returning to IDLE at mid-stop-bit lets a start edge half a bit later be caught.
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_ONE;
        end else if (rx_s) begin
          deliver   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          ferr_nxt  = 1'b1;
          state_nxt = ST_BREAK;
        end
      end
      ST_BREAK: begin
        if (rx_s) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      RX_DATA   <= '0;
      RX_VALID  <= 1'b0;
      FRAME_ERR <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      FRAME_ERR <= ferr_nxt;
      if (ERR_CLR) OVERRUN <= 1'b0;
      // Overrun set is evaluated after the clear so a coincident set wins.
      if (deliver) begin
        if (!RX_VALID || RX_READY) begin
          RX_DATA  <= shreg;
          RX_VALID <= 1'b1;
        end else begin
          OVERRUN <= 1'b1;
        end
      end else if (RX_VALID && RX_READY) begin
        RX_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_np_uart_rx.sv
// Bench for np_uart_rx: drives serial frames bit-by-bit and checks deliveries against a queue of expected bytes.
// Inputs change 2 ns after the rising edge; outputs are observed on the falling edge.
module tb_np_uart_rx;

  localparam int CPB = 106;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RX = 1'b1;
  logic       RX_READY = 1'b0;
  logic       ERR_CLR = 1'b0;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic       FRAME_ERR;
  logic       OVERRUN;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int   ferr_cnt = 0, ferr_run = 0, ferr_max = 0, vld_cycles = 0, rise_cyc = -1;
  logic prev_vld = 1'b0;

  always #5 CLK = ~CLK;

  np_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RX        (RX),
    .RX_DATA   (RX_DATA),
    .RX_VALID  (RX_VALID),
    .RX_READY  (RX_READY),
    .FRAME_ERR (FRAME_ERR),
    .OVERRUN   (OVERRUN),
    .ERR_CLR   (ERR_CLR)
  );

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (RX_VALID && RX_READY) got_q.push_back(RX_DATA);
    if (RX_VALID) vld_cycles++;
    if (RX_VALID && !prev_vld) rise_cyc = cyc;
    prev_vld = RX_VALID;
    if (FRAME_ERR) begin
      ferr_run++;
      if (ferr_run == 1) ferr_cnt++;
      if (ferr_run > ferr_max) ferr_max = ferr_run;
    end else begin
      ferr_run = 0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic clr_mon();
    got_q.delete();
    exp_q.delete();
    ferr_cnt   = 0;
    ferr_run   = 0;
    ferr_max   = 0;
    vld_cycles = 0;
    rise_cyc   = -1;
  endtask

  // One 8N1 frame; stop_low>0 holds the stop bit low for that many bit times before idling high.
  task automatic send_byte(input logic [7:0] b, input int stop_low);
    RX = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      tick(CPB);
    end
    if (stop_low > 0) begin
      RX = 1'b0;
      tick(stop_low * CPB);
    end
    RX = 1'b1;
    tick(CPB);
  endtask

  task automatic test_reset();
    tick(3);
    n_tests++;
    if (RX_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", RX_VALID); end
    n_tests++;
    if (RX_DATA !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", RX_DATA); end
    n_tests++;
    if (FRAME_ERR !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b want 0", FRAME_ERR); end
    n_tests++;
    if (OVERRUN !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %b want 0", OVERRUN); end
    RST = 1'b1;
    tick(5);
  endtask

  task automatic test_single();
    int t0;
    RX_READY = 1'b1;
    clr_mon();
    t0 = cyc;
    send_byte(8'h41, 0);
    tick(20);
    n_tests++;
    if (got_q.size() != 1 || got_q[0] !== 8'h41) begin
      n_fail++; $display("FAIL single_data: got %0d bytes first %h want 1 byte 41", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx);
    end
    n_tests++;
    if (vld_cycles != 1) begin n_fail++; $display("FAIL single_vld_len: got %0d cycles want 1", vld_cycles); end
    n_tests++;
    if (ferr_cnt != 0 || OVERRUN !== 1'b0) begin n_fail++; $display("FAIL single_err: ferr %0d ovr %b want 0 0", ferr_cnt, OVERRUN); end
    n_tests++;
    if (rise_cyc - t0 < 2 + CPB / 2 + 9 * CPB + 1 - 2 || rise_cyc - t0 > 2 + CPB / 2 + 9 * CPB + 1 + 2) begin
      n_fail++; $display("FAIL single_latency: got %0d want %0d +-2", rise_cyc - t0, 2 + CPB / 2 + 9 * CPB + 1);
    end
  endtask

  task automatic test_false_start();
    clr_mon();
    RX = 1'b0;
    tick(20);
    RX = 1'b1;
    tick(2 * CPB);
    n_tests++;
    if (vld_cycles != 0 || ferr_cnt != 0) begin n_fail++; $display("FAIL false_start_quiet: vld %0d ferr %0d want 0 0", vld_cycles, ferr_cnt); end
    send_byte(8'hA5, 0);
    tick(20);
    n_tests++;
    if (got_q.size() != 1 || got_q[0] !== 8'hA5) begin
      n_fail++; $display("FAIL false_start_next: got %0d bytes first %h want 1 byte a5", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx);
    end
  endtask

  task automatic test_frame_err();
    clr_mon();
    send_byte(8'h55, 3);
    tick(50);
    n_tests++;
    if (ferr_cnt != 1 || ferr_max != 1) begin n_fail++; $display("FAIL frame_err_pulse: pulses %0d max len %0d want 1 1", ferr_cnt, ferr_max); end
    n_tests++;
    if (vld_cycles != 0) begin n_fail++; $display("FAIL frame_err_novld: got %0d valid cycles want 0", vld_cycles); end
    send_byte(8'h0F, 0);
    tick(20);
    n_tests++;
    if (got_q.size() != 1 || got_q[0] !== 8'h0F) begin
      n_fail++; $display("FAIL frame_err_next: got %0d bytes first %h want 1 byte 0f", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx);
    end
  endtask

  task automatic test_overrun();
    RX_READY = 1'b0;
    clr_mon();
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    tick(20);
    n_tests++;
    if (RX_VALID !== 1'b1 || RX_DATA !== 8'h11) begin n_fail++; $display("FAIL overrun_hold: vld %b data %h want 1 11", RX_VALID, RX_DATA); end
    n_tests++;
    if (OVERRUN !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %b want 1", OVERRUN); end
    RX_READY = 1'b1;
    tick(1);
    RX_READY = 1'b0;
    tick(2);
    n_tests++;
    if (RX_VALID !== 1'b0 || got_q.size() != 1) begin n_fail++; $display("FAIL overrun_drain: vld %b accepted %0d want 0 1", RX_VALID, got_q.size()); end
    n_tests++;
    if (OVERRUN !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky: got %b want 1", OVERRUN); end
    ERR_CLR = 1'b1;
    tick(1);
    ERR_CLR = 1'b0;
    tick(1);
    n_tests++;
    if (OVERRUN !== 1'b0) begin n_fail++; $display("FAIL overrun_clear: got %b want 0", OVERRUN); end
    RX_READY = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq[3];
    seq[0] = 8'h00; seq[1] = 8'hFF; seq[2] = 8'h80;
    clr_mon();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(seq[i]);
      send_byte(seq[i], 0);
    end
    tick(20);
    n_tests++;
    if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_tests++;
    if (ferr_cnt != 0 || OVERRUN !== 1'b0) begin n_fail++; $display("FAIL b2b_err: ferr %0d ovr %b want 0 0", ferr_cnt, OVERRUN); end
  endtask

  task automatic test_mid_reset();
    logic [7:0] b;
    b = 8'h3C;
    clr_mon();
    RX = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      RX = b[i];
      tick(CPB);
    end
    RX = b[4];
    tick(30);
    RST = 1'b0;
    #1;
    n_tests++;
    if ({RX_VALID, FRAME_ERR, OVERRUN, RX_DATA} !== 11'd0) begin
      n_fail++; $display("FAIL mid_reset_outputs: vld %b ferr %b ovr %b data %h want all 0", RX_VALID, FRAME_ERR, OVERRUN, RX_DATA);
    end
    tick(5);
    RST = 1'b1;
    RX = 1'b1;
    tick((CPB - 35) + 4 * CPB);
    n_tests++;
    if (vld_cycles != 0 || ferr_cnt != 0) begin n_fail++; $display("FAIL mid_reset_partial: vld %0d ferr %0d want 0 0", vld_cycles, ferr_cnt); end
    send_byte(8'hC3, 0);
    tick(20);
    n_tests++;
    if (got_q.size() != 1 || got_q[0] !== 8'hC3) begin
      n_fail++; $display("FAIL mid_reset_next: got %0d bytes first %h want 1 byte c3", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    int exp_ferr, stop_low;
    exp_ferr = 0;
    clr_mon();
    for (int n = 0; n < 12; n++) begin
      b = 8'($urandom);
      stop_low = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
      if (stop_low == 0) exp_q.push_back(b);
      else               exp_ferr++;
      send_byte(b, stop_low);
      tick(int'($urandom_range(0, 60)));
    end
    tick(20);
    n_tests++;
    if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_tests++;
    if (ferr_cnt != exp_ferr || ferr_max > 1) begin n_fail++; $display("FAIL rand_ferr: pulses %0d max len %0d want %0d 1", ferr_cnt, ferr_max, exp_ferr); end
    n_tests++;
    if (OVERRUN !== 1'b0) begin n_fail++; $display("FAIL rand_ovr: got %b want 0", OVERRUN); end
  endtask

  initial begin
    #1 RST = 1'b0;
    test_reset();
    test_single();
    test_false_start();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
